// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// port and the load/store port. Round-robin on ties, registered outputs and
// a wait-state watchdog that completes a stuck access with an error.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          gnt_d
);

  // Wide enough to hold TIMEOUT-1; the expiry check fires before any wrap.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t          state_reg, state_next;
  logic            last_d_reg, last_d_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            m_req_reg, m_req_next;
  logic            m_we_reg, m_we_next;
  logic [AW-1:0]   m_addr_reg, m_addr_next;
  logic [DW-1:0]   m_wdata_reg, m_wdata_next;
  logic [DW-1:0]   i_rdata_reg, i_rdata_next;
  logic            i_ack_reg, i_ack_next;
  logic            i_err_reg, i_err_next;
  logic [DW-1:0]   d_rdata_reg, d_rdata_next;
  logic            d_ack_reg, d_ack_next;
  logic            d_err_reg, d_err_next;
  logic            gnt_d_reg, gnt_d_next;
  logic            wd_expire;
  logic            grant_d;

  // Watchdog fires on the last allowed wait cycle; an m_ack in that same
  // cycle takes priority in the FSM below.
  assign wd_expire = (TIMEOUT != 0) && (cnt_reg == CW'(TIMEOUT - 1));

  // Data wins in IDLE if it is alone, or if both wait and fetch went last.
  assign grant_d = d_req && (!i_req || !last_d_reg);

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      last_d_reg  <= 1'b1;
      cnt_reg     <= '0;
      m_req_reg   <= 1'b0;
      m_we_reg    <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      i_rdata_reg <= '0;
      i_ack_reg   <= 1'b0;
      i_err_reg   <= 1'b0;
      d_rdata_reg <= '0;
      d_ack_reg   <= 1'b0;
      d_err_reg   <= 1'b0;
      gnt_d_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_d_reg  <= last_d_next;
      cnt_reg     <= cnt_next;
      m_req_reg   <= m_req_next;
      m_we_reg    <= m_we_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
      i_rdata_reg <= i_rdata_next;
      i_ack_reg   <= i_ack_next;
      i_err_reg   <= i_err_next;
      d_rdata_reg <= d_rdata_next;
      d_ack_reg   <= d_ack_next;
      d_err_reg   <= d_err_next;
      gnt_d_reg   <= gnt_d_next;
    end
  end

  // Next-state and next-output logic; acks are single-cycle pulses by default.
  always_comb begin
    state_next   = state_reg;
    last_d_next  = last_d_reg;
    cnt_next     = cnt_reg;
    m_req_next   = m_req_reg;
    m_we_next    = m_we_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    i_rdata_next = i_rdata_reg;
    i_ack_next   = 1'b0;
    i_err_next   = 1'b0;
    d_rdata_next = d_rdata_reg;
    d_ack_next   = 1'b0;
    d_err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          m_addr_next  = d_addr;
          m_we_next    = d_we;
          m_wdata_next = d_wdata;
          m_req_next   = 1'b1;
          cnt_next     = '0;
          last_d_next  = 1'b1;
          state_next   = BUSY_D;
        end else if (i_req) begin
          m_addr_next  = i_addr;
          m_we_next    = 1'b0;
          m_req_next   = 1'b1;
          cnt_next     = '0;
          last_d_next  = 1'b0;
          state_next   = BUSY_I;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          m_req_next   = 1'b0;
          m_we_next    = 1'b0;
          i_rdata_next = m_rdata;
          i_ack_next   = 1'b1;
          state_next   = RESP_I;
        end else if (wd_expire) begin
          m_req_next   = 1'b0;
          m_we_next    = 1'b0;
          i_rdata_next = '0;
          i_ack_next   = 1'b1;
          i_err_next   = 1'b1;
          state_next   = RESP_I;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          m_req_next = 1'b0;
          m_we_next  = 1'b0;
          if (!m_we_reg) begin
            d_rdata_next = m_rdata;
          end
          d_ack_next = 1'b1;
          state_next = RESP_D;
        end else if (wd_expire) begin
          m_req_next   = 1'b0;
          m_we_next    = 1'b0;
          d_rdata_next = '0;
          d_ack_next   = 1'b1;
          d_err_next   = 1'b1;
          state_next   = RESP_D;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP_I, RESP_D: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    gnt_d_next = (state_next == BUSY_D) || (state_next == RESP_D);
  end

  assign m_req   = m_req_reg;
  assign m_we    = m_we_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign i_rdata = i_rdata_reg;
  assign i_ack   = i_ack_reg;
  assign i_err   = i_err_reg;
  assign d_rdata = d_rdata_reg;
  assign d_ack   = d_ack_reg;
  assign d_err   = d_err_reg;
  assign gnt_d   = gnt_d_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed requester traffic, a wait-state memory
// model, and scoreboard monitors for memory requests and requester acks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack, i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        gnt_d;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .gnt_d(gnt_d)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } mexp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rexp_t;

  mexp_t mq[$];
  rexp_t iq[$];
  rexp_t dq[$];

  function automatic void exp_mem(logic is_d, logic we, logic [31:0] addr,
                                  logic [31:0] wdata, int len);
    mexp_t e;
    e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.len = len;
    mq.push_back(e);
  endfunction

  // Memory model: acks after mem_wait wait states; writes return junk rdata.
  int mem_wait = 0;
  logic [31:0] mem [logic [31:0]];
  initial begin
    int waits;
    waits = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset || !m_req) begin
        m_ack = 1'b0;
        waits = 0;
      end else if (m_ack) begin
        m_ack = 1'b0;
      end else if (waits == mem_wait) begin
        m_ack = 1'b1;
        if (m_we) begin
          mem[m_addr] = m_wdata;
          m_rdata = 32'hDEAD_BEEF;
        end else begin
          m_rdata = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
        end
      end else begin
        waits++;
      end
    end
  end

  // Monitor: memory request order, attributes, stability and length; acks.
  initial begin
    mexp_t cur;
    logic  prev;
    int    len;
    rexp_t r;
    prev = 1'b0;
    len  = 0;
    cur  = '{default: '0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b0;
      end else begin
        if (m_req && !prev) begin
          check("mreq_expected", (mq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (mq.size() != 0) begin
            cur = mq.pop_front();
            check("m_addr", m_addr, cur.addr);
            check("m_we", {31'b0, m_we}, {31'b0, cur.we});
            check("gnt_d_start", {31'b0, gnt_d}, {31'b0, cur.is_d});
            if (cur.we) check("m_wdata", m_wdata, cur.wdata);
          end
          len = 1;
        end else if (m_req) begin
          len++;
          check("m_addr_stable", m_addr, cur.addr);
          check("m_we_stable", {31'b0, m_we}, {31'b0, cur.we});
        end else if (prev && cur.len != 0) begin
          check("m_req_len", len, cur.len);
        end
        prev = m_req;

        check("no_dual_ack", {31'b0, i_ack & d_ack}, 32'd0);
        if (i_ack) begin
          $display("txn fetch ack rdata=%h err=%0d", i_rdata, i_err);
          check("i_ack_expected", (iq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (iq.size() != 0) begin
            r = iq.pop_front();
            check("i_rdata", i_rdata, r.rdata);
            check("i_err", {31'b0, i_err}, {31'b0, r.err});
            check("gnt_d_fetch", {31'b0, gnt_d}, 32'd0);
          end
        end
        if (d_ack) begin
          $display("txn data ack rdata=%h err=%0d", d_rdata, d_err);
          check("d_ack_expected", (dq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (dq.size() != 0) begin
            r = dq.pop_front();
            check("d_rdata", d_rdata, r.rdata);
            check("d_err", {31'b0, d_err}, {31'b0, r.err});
            check("gnt_d_data", {31'b0, gnt_d}, 32'd1);
          end
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_rdata,
                          input logic exp_err);
    rexp_t r;
    logic  got;
    r.err = exp_err; r.rdata = exp_rdata;
    iq.push_back(r);
    i_addr = addr;
    i_req  = 1'b1;
    got    = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = i_ack;
    end
    check("i_ack_wait", {31'b0, got}, 32'd1);
    i_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    rexp_t r;
    logic  got;
    r.err = exp_err; r.rdata = exp_rdata;
    dq.push_back(r);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    got     = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = d_ack;
    end
    check("d_ack_wait", {31'b0, got}, 32'd1);
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    mem[32'h0000_0040] = 32'h2001_0005;
    mem[32'h0000_0044] = 32'h0000_1111;
    mem[32'h0000_0200] = 32'h1234_5678;

    // Reset state
    #1;
    check("rst_m_req", {31'b0, m_req}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
    check("rst_gnt_d", {31'b0, gnt_d}, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 1: zero-wait fetch, latency m_req at cycle 1, ack at cycle 2
    mem_wait = 0;
    exp_mem(1'b0, 1'b0, 32'h40, 32'h0, 1);
    iq.push_back('{err: 1'b0, rdata: 32'h2001_0005});
    i_addr = 32'h40;
    i_req  = 1'b1;
    @(negedge clk);
    check("t1_m_req_cyc1", {31'b0, m_req}, 32'd1);
    @(negedge clk);
    check("t1_i_ack_cyc2", {31'b0, i_ack}, 32'd1);
    i_req = 1'b0;
    @(negedge clk);
    check("t1_i_ack_pulse", {31'b0, i_ack}, 32'd0);

    // 2: tie from reset -> fetch, then data write; second tie -> fetch
    do_reset();
    exp_mem(1'b0, 1'b0, 32'h40, 32'h0, 1);
    exp_mem(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 1);
    fork
      do_fetch(32'h40, 32'h2001_0005, 1'b0);
      do_data(1'b1, 32'h100, 32'hCAFE_F00D, 32'h0, 1'b0);
    join
    exp_mem(1'b0, 1'b0, 32'h44, 32'h0, 1);
    exp_mem(1'b1, 1'b0, 32'h100, 32'h0, 1);
    fork
      do_fetch(32'h44, 32'h0000_1111, 1'b0);
      do_data(1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0);
    join
    // After a lone fetch, a tie goes to data
    exp_mem(1'b0, 1'b0, 32'h40, 32'h0, 1);
    do_fetch(32'h40, 32'h2001_0005, 1'b0);
    exp_mem(1'b1, 1'b0, 32'h100, 32'h0, 1);
    exp_mem(1'b0, 1'b0, 32'h44, 32'h0, 1);
    fork
      do_fetch(32'h44, 32'h0000_1111, 1'b0);
      do_data(1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0);
    join

    // 3: data read with 3 wait states
    mem_wait = 3;
    exp_mem(1'b1, 1'b0, 32'h200, 32'h0, 4);
    do_data(1'b0, 32'h200, 32'h0, 32'h1234_5678, 1'b0);

    // 4: fetch never acked -> watchdog after 16 cycles, then a normal fetch
    mem_wait = 1000;
    exp_mem(1'b0, 1'b0, 32'h80, 32'h0, 16);
    do_fetch(32'h80, 32'h0, 1'b1);
    mem_wait = 0;
    exp_mem(1'b0, 1'b0, 32'h40, 32'h0, 1);
    do_fetch(32'h40, 32'h2001_0005, 1'b0);

    // 5: ack in the 16th cycle is a success
    mem_wait = 15;
    exp_mem(1'b1, 1'b0, 32'h200, 32'h0, 16);
    do_data(1'b0, 32'h200, 32'h0, 32'h1234_5678, 1'b0);

    // 6: reset in BUSY_D abandons the transfer
    mem_wait = 1000;
    exp_mem(1'b1, 1'b0, 32'h300, 32'h0, 0);
    d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = m_req;
    end
    check("t6_m_req_wait", {31'b0, seen}, 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_m_req_rst", {31'b0, m_req}, 32'd0);
    check("t6_gnt_d_rst", {31'b0, gnt_d}, 32'd0);
    check("t6_m_addr_rst", m_addr, 32'd0);
    check("t6_d_ack_rst", {31'b0, d_ack}, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_wait = 0;
    exp_mem(1'b0, 1'b0, 32'h40, 32'h0, 1);
    exp_mem(1'b1, 1'b0, 32'h200, 32'h0, 1);
    fork
      do_fetch(32'h40, 32'h2001_0005, 1'b0);
      do_data(1'b0, 32'h200, 32'h0, 32'h1234_5678, 1'b0);
    join

    repeat (4) @(negedge clk);
    check("leftover_mem", mq.size(), 32'd0);
    check("leftover_i", iq.size(), 32'd0);
    check("leftover_d", dq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
